bip_control_acc: RTL and testbench

- Control unit and accumulator stage of the accumulator-based processor.
- Fetches and decodes instructions and sequences program and data memory.
- Holds the accumulator register that drives the ALU's Entrada_Acc input, and consumes the ALU's Salida result on arithmetic instructions.
- Also generates the ALU Op select and the second-operand mux (Entrada_Mult).

---
 rtl/bip_pkg.sv | 40 ++++
 rtl/bip_control_acc_if.sv | 28 ++
 rtl/bip_decoder.sv | 44 ++++
 rtl/bip_control_acc.sv | 100 ++++++++++
 tb/tb_bip_control_acc.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bip_pkg.sv
// Shared widths, opcodes and the FSM state encoding for the BIP control unit.
// Branch opcodes are only decoded when BIP_BRANCH_EN is defined.
package bip_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 11;
    localparam int OPC_W  = 5;

    localparam logic [OPC_W-1:0] OPC_HLT  = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;
    localparam logic [OPC_W-1:0] OPC_BEQ  = 5'b01000;
    localparam logic [OPC_W-1:0] OPC_JMP  = 5'b01001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ACC_MEM = 2'd0,
        ACC_IMM = 2'd1,
        ACC_ALU = 2'd2
    } acc_src_t;

    // The operand field is signed; bit 10 is replicated up to the data width.
    function automatic logic [DATA_W-1:0] sext_imm(input logic [ADDR_W-1:0] imm);
        return {{(DATA_W-ADDR_W){imm[ADDR_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/bip_control_acc_if.sv
// Memory and ALU bus between the BIP control unit (master) and the
// program/data memories plus ALU (slave).
interface bip_control_acc_if;

    logic [bip_pkg::DATA_W-1:0] Instr;
    logic [bip_pkg::ADDR_W-1:0] Addr_Prog;
    logic [bip_pkg::DATA_W-1:0] Dato_Ram;
    logic [bip_pkg::ADDR_W-1:0] Addr_Ram;
    logic [bip_pkg::DATA_W-1:0] Dato_Escritura;
    logic                       WrRam;
    logic [bip_pkg::DATA_W-1:0] Salida_Alu;
    logic [bip_pkg::DATA_W-1:0] Entrada_Acc;
    logic [bip_pkg::DATA_W-1:0] Entrada_Mult;
    logic                       Op;

    modport master (
        input  Instr, Dato_Ram, Salida_Alu,
        output Addr_Prog, Addr_Ram, Dato_Escritura, WrRam,
               Entrada_Acc, Entrada_Mult, Op
    );

    modport slave (
        output Instr, Dato_Ram, Salida_Alu,
        input  Addr_Prog, Addr_Ram, Dato_Escritura, WrRam,
               Entrada_Acc, Entrada_Mult, Op
    );

endinterface

// File: rtl/bip_decoder.sv
// Combinational opcode-to-control decode for the BIP control unit.
// BEQ/JMP are recognised as branches only when BIP_BRANCH_EN is defined.
module bip_decoder
    import bip_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output logic             Op,
    output logic             SelImm,
    output logic             WrAcc,
    output acc_src_t         AccSrc,
    output logic             IsSto,
    output logic             IsHlt,
    output logic             IsBranch
);

    // Opcode bit 0 (IR[11]) marks the immediate forms of every instruction.
    assign SelImm = opcode[0];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        Op       = 1'b0;
        WrAcc    = 1'b0;
        AccSrc   = ACC_ALU;
        IsSto    = 1'b0;
        IsHlt    = 1'b0;
        IsBranch = 1'b0;
        case (opcode)
            OPC_HLT:  IsHlt = 1'b1;
            OPC_STO:  IsSto = 1'b1;
            OPC_LD:   begin WrAcc = 1'b1; AccSrc = ACC_MEM; end
            OPC_LDI:  begin WrAcc = 1'b1; AccSrc = ACC_IMM; end
            OPC_ADD,
            OPC_ADDI: WrAcc = 1'b1;
            OPC_SUB,
            OPC_SUBI: begin WrAcc = 1'b1; Op = 1'b1; end
`ifdef BIP_BRANCH_EN
            OPC_BEQ,
            OPC_JMP:  IsBranch = 1'b1;
`endif
            default:  ;
        endcase
    end

endmodule

// File: rtl/bip_control_acc.sv
// Control unit and accumulator of the BIP processor: fetch/decode FSM, PC, IR,
// Acc and cycle counter. Define BIP_BRANCH_EN to enable the BEQ/JMP opcodes.
module bip_control_acc
    import bip_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               Start,
    output logic               Halted,
    output logic [15:0]        Ciclos,
    bip_control_acc_if.master  bus
);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] acc;

    logic     dec_op;
    logic     sel_imm;
    logic     wr_acc;
    acc_src_t acc_src;
    logic     is_sto;
    logic     is_hlt;
    logic     is_branch;
    logic     pc_load;

    logic [DATA_W-1:0] imm_ext;

    bip_decoder u_decoder (
        .opcode   (ir[DATA_W-1 -: OPC_W]),
        .Op       (dec_op),
        .SelImm   (sel_imm),
        .WrAcc    (wr_acc),
        .AccSrc   (acc_src),
        .IsSto    (is_sto),
        .IsHlt    (is_hlt),
        .IsBranch (is_branch)
    );

    assign imm_ext = sext_imm(ir[ADDR_W-1:0]);

    // JMP carries IR[11]=1, BEQ carries IR[11]=0 and needs a zero accumulator.
    assign pc_load = is_branch & (sel_imm | (acc == '0));

    assign bus.Addr_Prog      = pc;
    assign bus.Addr_Ram       = ir[ADDR_W-1:0];
    assign bus.Dato_Escritura = acc;
    assign bus.Entrada_Acc    = acc;
    assign bus.Entrada_Mult   = sel_imm ? imm_ext : bus.Dato_Ram;
    assign bus.Op             = dec_op;
    // Decode of two registers; a reset ending the MEM cycle leaves IDLE with no strobe.
    assign bus.WrRam          = (state == ST_MEM) & is_sto;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state  <= ST_IDLE;
            pc     <= '0;
            ir     <= '0;
            acc    <= '0;
            Ciclos <= '0;
            Halted <= 1'b0;
        end else begin
            if (state != ST_IDLE && state != ST_HALT && Ciclos != 16'hFFFF)
                Ciclos <= Ciclos + 16'd1;
            case (state)
                ST_IDLE:   if (Start) state <= ST_FETCH;
                ST_FETCH:  state <= ST_DECODE;
                ST_DECODE: begin
                    ir    <= bus.Instr;
                    state <= ST_MEM;
                end
                ST_MEM: begin
                    if (is_hlt) begin
                        state  <= ST_HALT;
                        Halted <= 1'b1;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (wr_acc) begin
                        case (acc_src)
                            ACC_MEM: acc <= bus.Dato_Ram;
                            ACC_IMM: acc <= imm_ext;
                            ACC_ALU: acc <= bus.Salida_Alu;
                            default: acc <= acc;
                        endcase
                    end
                    pc    <= pc_load ? ir[ADDR_W-1:0] : pc + 1'b1;
                    state <= ST_FETCH;
                end
                ST_HALT:   state <= ST_HALT;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bip_control_acc.sv
// Self-checking bench for bip_control_acc: memories and ALU in the loop, an
// instruction-level reference model compared every cycle, plus directed literals.
module tb_bip_control_acc;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        halted;
    logic [15:0] ciclos;

    bip_control_acc_if bus();

    bip_control_acc dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (start),
        .Halted (halted),
        .Ciclos (ciclos),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous memories and a combinational add/subtract ALU.
    logic [15:0] prog [0:2047];
    logic [15:0] ram  [0:2047];

    always @(posedge clk) begin
        bus.Instr    <= prog[bus.Addr_Prog];
        bus.Dato_Ram <= ram[bus.Addr_Ram];
        if (bus.WrRam === 1'b1) ram[bus.Addr_Ram] <= bus.Dato_Escritura;
    end

    assign bus.Salida_Alu = bus.Op ? bus.Entrada_Acc - bus.Entrada_Mult
                                   : bus.Entrada_Acc + bus.Entrada_Mult;

    // Reference model: architectural state, advanced one instruction per 4 cycles.
    logic [15:0] m_ram [0:2047];
    logic        m_active = 1'b0;
    logic        m_halt   = 1'b0;
    int          m_phase  = 0;
    logic [10:0] m_pc     = '0;
    logic [15:0] m_acc    = '0;
    logic [15:0] m_cyc    = '0;
    logic [15:0] m_ir     = '0;
    logic [4:0]  m_opc;
    logic [10:0] m_a;
    logic [15:0] m_imm;
    logic [10:0] m_npc;

    always @(posedge clk) begin
        m_opc = m_ir[15:11];
        m_a   = m_ir[10:0];
        m_imm = {{5{m_ir[10]}}, m_ir[10:0]};
        if (reset) begin
            m_active = 1'b0; m_halt = 1'b0; m_phase = 0;
            m_pc = '0; m_acc = '0; m_cyc = '0; m_ir = '0;
        end else if (m_active) begin
            if (m_cyc != 16'hFFFF) m_cyc = m_cyc + 16'd1;
            case (m_phase)
                0: m_phase = 1;
                1: begin m_ir = prog[m_pc]; m_phase = 2; end
                2: begin
                    if (m_opc == 5'd0) begin
                        m_active = 1'b0;
                        m_halt   = 1'b1;
                    end else begin
                        if (m_opc == 5'd1) m_ram[m_a] = m_acc;
                        m_phase = 3;
                    end
                end
                default: begin
                    m_npc = m_pc + 11'd1;
                    case (m_opc)
                        5'd2: m_acc = m_ram[m_a];
                        5'd3: m_acc = m_imm;
                        5'd4: m_acc = m_acc + m_ram[m_a];
                        5'd5: m_acc = m_acc + m_imm;
                        5'd6: m_acc = m_acc - m_ram[m_a];
                        5'd7: m_acc = m_acc - m_imm;
`ifdef BIP_BRANCH_EN
                        5'd8: if (m_acc == 16'd0) m_npc = m_a;
                        5'd9: m_npc = m_a;
`endif
                        default: ;
                    endcase
                    m_pc    = m_npc;
                    m_phase = 0;
                end
            endcase
        end else if (!m_halt && start) begin
            m_active = 1'b1;
            m_phase  = 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    logic chk_en = 1'b0;
    logic [15:0] e_mult;

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_addr_prog", bus.Addr_Prog, m_pc);
            check("cyc_acc",       bus.Entrada_Acc, m_acc);
            check("cyc_ciclos",    ciclos, m_cyc);
            check("cyc_halted",    halted, m_halt);
            check("cyc_addr_ram",  bus.Addr_Ram, m_ir[10:0]);
            check("cyc_op",        bus.Op, (m_ir[15:11] == 5'd6 || m_ir[15:11] == 5'd7));
            check("cyc_wrram",     bus.WrRam, (m_active && m_phase == 2 && m_ir[15:11] == 5'd1));
            if (bus.WrRam === 1'b1) check("cyc_wr_data", bus.Dato_Escritura, m_acc);
            if (m_active && m_phase == 3 && m_ir[15:11] != 5'd1) begin
                e_mult = m_ir[11] ? {{5{m_ir[10]}}, m_ir[10:0]} : m_ram[m_ir[10:0]];
                check("cyc_mult", bus.Entrada_Mult, e_mult);
            end
        end
    end

    // Write-strobe monitor for the directed STO checks.
    int          wr_cnt = 0;
    logic [10:0] wr_addr;
    logic [15:0] wr_data;

    always @(negedge clk) begin
        if (bus.WrRam === 1'b1) begin
            wr_cnt++;
            wr_addr = bus.Addr_Ram;
            wr_data = bus.Dato_Escritura;
        end
    end

`ifdef BIP_BRANCH_EN
    localparam logic [10:0] EXP_BRANCH_PC = 11'd4;
`else
    localparam logic [10:0] EXP_BRANCH_PC = 11'd2;
`endif

    task automatic begin_load();
        @(posedge clk); #2;
        reset = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            prog[i]  = 16'h0000;
            ram[i]   = 16'h0000;
            m_ram[i] = 16'h0000;
        end
    endtask

    task automatic end_load();
        @(posedge clk); #2;
        reset  = 1'b0;
        wr_cnt = 0;
    endtask

    // Start is sampled on the next edge; returns in cycle 0 (FETCH) of the run.
    task automatic start_run();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_halt(input int max_cycles);
        for (int i = 0; i < max_cycles && halted !== 1'b1; i++) step(1);
        check("halt_reached", halted, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            prog[i] = 16'h0000; ram[i] = 16'h0000; m_ram[i] = 16'h0000;
        end
        @(posedge clk); #2;
        chk_en = 1'b1;

        // Idle after reset with Start low.
        end_load();
        for (int i = 0; i < 10; i++) begin
            check("idle_addr_prog", bus.Addr_Prog, 11'd0);
            check("idle_acc",       bus.Entrada_Acc, 16'd0);
            check("idle_ciclos",    ciclos, 16'd0);
            check("idle_halted",    halted, 1'b0);
            step(1);
        end

        // LDI 5; ADDI 3; HLT
        begin_load();
        prog[0] = 16'h1805; prog[1] = 16'h2803; prog[2] = 16'h0000;
        end_load();
        start_run();
        step(8);
        check("addi_acc", bus.Entrada_Acc, 16'd8);
        wait_halt(20);
        check("p1_halted", halted, 1'b1);
        check("p1_pc",     bus.Addr_Prog, 11'd2);
        check("p1_ciclos", ciclos, 16'd11);
        check("p1_acc",    bus.Entrada_Acc, 16'd8);

        // mem[7]=0x10; LD 7; SUBI 1; STO 9; HLT
        begin_load();
        ram[7] = 16'h0010; m_ram[7] = 16'h0010;
        prog[0] = 16'h1007; prog[1] = 16'h3801; prog[2] = 16'h0809; prog[3] = 16'h0000;
        end_load();
        start_run();
        step(6);
        check("subi_op", bus.Op, 1'b1);
        wait_halt(30);
        check("sto_pulses",  wr_cnt, 32'd1);
        check("sto_addr",    wr_addr, 11'd9);
        check("sto_data",    wr_data, 16'h000F);
        check("sto_ram9",    ram[9], 16'h000F);
        check("p2_ciclos",   ciclos, 16'd15);
        check("p2_pc",       bus.Addr_Prog, 11'd3);

        // LDI 0x7FF; ADDI 1; HLT
        begin_load();
        prog[0] = 16'h1FFF; prog[1] = 16'h2801; prog[2] = 16'h0000;
        end_load();
        start_run();
        step(4);
        check("ldi_sext", bus.Entrada_Acc, 16'hFFFF);
        step(4);
        check("addi_wrap", bus.Entrada_Acc, 16'h0000);
        wait_halt(20);

        // Reset during MEM of a STO: LDI 3; STO 9; HLT
        begin_load();
        prog[0] = 16'h1803; prog[1] = 16'h0809; prog[2] = 16'h0000;
        end_load();
        start_run();
        step(6);
        check("sto_mem_wrram", bus.WrRam, 1'b1);
        reset = 1'b1;
        step(1);
        check("rst_wrram",  bus.WrRam, 1'b0);
        check("rst_acc",    bus.Entrada_Acc, 16'd0);
        check("rst_pc",     bus.Addr_Prog, 11'd0);
        check("rst_ciclos", ciclos, 16'd0);
        check("rst_halted", halted, 1'b0);
        reset = 1'b0;
        step(3);
        check("rst_idle_ciclos", ciclos, 16'd0);
        check("rst_pulses",      wr_cnt, 32'd1);

        // LDI 0; BEQ 4; HLT x3
        begin_load();
        prog[0] = 16'h1800; prog[1] = 16'h4004;
        end_load();
        start_run();
        step(8);
        check("branch_pc", bus.Addr_Prog, EXP_BRANCH_PC);
        wait_halt(20);
        check("branch_halt_pc", bus.Addr_Prog, EXP_BRANCH_PC);
        check("branch_ciclos",  ciclos, 16'd11);

        // Start is ignored once halted.
        start_run();
        step(5);
        check("halt_sticky", halted, 1'b1);
        check("halt_frozen", ciclos, 16'd11);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
